// File: rtl/keypad_conditioner.sv
// Button front end: synchronise, debounce, detect presses and arbitrate them into
// one-hot, single-cycle pulses for the door FSM.
module keypad_conditioner #(
    parameter int NUM_BTN         = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [NUM_BTN-1:0] btn_held,
    output logic               multi_press,
    output logic               activity
);

    localparam int            CW     = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_TC = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] sync_q [SYNC_STAGES];
    logic [NUM_BTN-1:0] sync_s;

    logic [CW-1:0]      cnt_q  [NUM_BTN];
    logic [CW-1:0]      cnt_d  [NUM_BTN];
    logic [NUM_BTN-1:0] held_q, held_d;
    logic [NUM_BTN-1:0] rise;

    logic [NUM_BTN-1:0] pulse_q, pulse_d;
    logic               multi_q, multi_d;
    logic               act_q, act_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '0;
            end
        end else begin
            sync_q[0] <= btn_raw;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Any sample equal to the held level clears the count, so a glitch restarts it.
    always_comb begin
        held_d = held_q;
        rise   = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_d[i] = '0;
            if (sync_s[i] != held_q[i]) begin
                if (cnt_q[i] == CNT_TC) begin
                    held_d[i] = sync_s[i];
                    rise[i]   = sync_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // A press is accepted only when it is the sole rise and nothing else is already held.
    always_comb begin
        pulse_d = '0;
        multi_d = 1'b0;
        if (rise != '0) begin
            if ($onehot(rise) && (held_q == '0)) begin
                pulse_d = rise;
            end else begin
                multi_d = 1'b1;
            end
        end
    end

    assign act_d = |held_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            held_q  <= '0;
            pulse_q <= '0;
            multi_q <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            held_q  <= held_d;
            pulse_q <= pulse_d;
            multi_q <= multi_d;
            act_q   <= act_d;
        end
    end

    assign btn_pulse   = pulse_q;
    assign btn_held    = held_q;
    assign multi_press = multi_q;
    assign activity    = act_q;

endmodule

// File: tb/tb_keypad_conditioner.sv
// Directed bench for keypad_conditioner: latency, bounce rejection, arbitration,
// async reset and a key sequence, all against hand-computed values.
module tb_keypad_conditioner;

    logic       clk;
    logic       reset_n;
    logic [3:0] btn_raw;
    logic [3:0] btn_pulse;
    logic [3:0] btn_held;
    logic       multi_press;
    logic       activity;

    int n_tests = 0;
    int n_fail  = 0;

    keypad_conditioner #(
        .NUM_BTN        (4),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_raw    (btn_raw),
        .btn_pulse  (btn_pulse),
        .btn_held   (btn_held),
        .multi_press(multi_press),
        .activity   (activity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // n rising edges, then park on the following falling edge
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Raw level was just applied; expect quiet for 9 cycles, then the given pulse/multi.
    task automatic press_expect(input string tag, input logic [3:0] exp_pulse, input logic exp_multi);
        for (int c = 1; c <= 10; c++) begin
            cyc(1);
            if (c < 10) begin
                chk({tag, "_early_pulse"}, btn_pulse, 4'b0000);
                chk({tag, "_early_multi"}, multi_press, 1'b0);
            end else begin
                chk({tag, "_pulse"}, btn_pulse, exp_pulse);
                chk({tag, "_multi"}, multi_press, exp_multi);
            end
        end
    endtask

    initial begin
        reset_n = 1'b1;
        btn_raw = 4'b0000;
        #1 reset_n = 1'b0;
        cyc(2);
        chk("rst_pulse", btn_pulse, 4'b0000);
        chk("rst_held", btn_held, 4'b0000);
        chk("rst_multi", multi_press, 1'b0);
        chk("rst_act", activity, 1'b0);

        // 1: single press, latency and no repeat while held
        reset_n = 1'b1;
        btn_raw = 4'b0001;
        press_expect("t1", 4'b0001, 1'b0);
        chk("t1_held", btn_held, 4'b0001);
        chk("t1_act", activity, 1'b1);
        for (int c = 0; c < 20; c++) begin
            cyc(1);
            chk("t1_hold_pulse", btn_pulse, 4'b0000);
        end
        chk("t1_held_still", btn_held, 4'b0001);
        btn_raw = 4'b0000;
        for (int c = 1; c <= 10; c++) begin
            cyc(1);
            chk("t1_rel_pulse", btn_pulse, 4'b0000);
            chk("t1_rel_multi", multi_press, 1'b0);
        end
        chk("t1_rel_held", btn_held, 4'b0000);
        chk("t1_rel_act", activity, 1'b0);
        cyc(5);

        // 2: bounce on button 3 then stable
        btn_raw = 4'b0100; cyc(1);
        chk("t2_bounce", btn_pulse, 4'b0000);
        btn_raw = 4'b0000; cyc(1);
        chk("t2_bounce", btn_pulse, 4'b0000);
        btn_raw = 4'b0100; cyc(2);
        chk("t2_bounce", btn_pulse, 4'b0000);
        btn_raw = 4'b0000; cyc(2);
        chk("t2_bounce", btn_pulse, 4'b0000);
        chk("t2_bounce_held", btn_held, 4'b0000);
        btn_raw = 4'b0100;
        press_expect("t2", 4'b0100, 1'b0);
        chk("t2_held", btn_held, 4'b0100);
        cyc(1);
        chk("t2_one_wide", btn_pulse, 4'b0000);
        btn_raw = 4'b0000;
        cyc(12);
        chk("t2_rel_held", btn_held, 4'b0000);

        // 3: simultaneous presses
        btn_raw = 4'b0011;
        press_expect("t3", 4'b0000, 1'b1);
        chk("t3_held", btn_held, 4'b0011);
        chk("t3_act", activity, 1'b1);
        cyc(1);
        chk("t3_multi_one_wide", multi_press, 1'b0);
        chk("t3_pulse_after", btn_pulse, 4'b0000);
        btn_raw = 4'b0000;
        cyc(12);
        chk("t3_rel_held", btn_held, 4'b0000);

        // 4: press while another button is held
        btn_raw = 4'b0001;
        press_expect("t4a", 4'b0001, 1'b0);
        cyc(5);
        btn_raw = 4'b1001;
        press_expect("t4b", 4'b0000, 1'b1);
        chk("t4_held", btn_held, 4'b1001);
        cyc(1);
        chk("t4_multi_one_wide", multi_press, 1'b0);
        btn_raw = 4'b0000;
        for (int c = 0; c < 12; c++) begin
            cyc(1);
            chk("t4_rel_pulse", btn_pulse, 4'b0000);
            chk("t4_rel_multi", multi_press, 1'b0);
        end
        chk("t4_rel_held", btn_held, 4'b0000);
        chk("t4_rel_act", activity, 1'b0);

        // 5a: async reset clears registered outputs without a clock edge
        btn_raw = 4'b0010;
        press_expect("t5a", 4'b0010, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("t5a_async_pulse", btn_pulse, 4'b0000);
        chk("t5a_async_held", btn_held, 4'b0000);
        chk("t5a_async_act", activity, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        press_expect("t5b", 4'b0010, 1'b0);
        btn_raw = 4'b0000;
        cyc(12);

        // 5c: reset mid-debounce, release with button still down
        btn_raw = 4'b0010;
        cyc(5);
        reset_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cyc(1);
            chk("t5c_in_rst_pulse", btn_pulse, 4'b0000);
            chk("t5c_in_rst_held", btn_held, 4'b0000);
        end
        reset_n = 1'b1;
        press_expect("t5c", 4'b0010, 1'b0);
        chk("t5c_held", btn_held, 4'b0010);
        btn_raw = 4'b0000;
        cyc(12);

        // 6: key sequence 1,3,2,4
        btn_raw = 4'b0001; press_expect("t6_k1", 4'b0001, 1'b0);
        cyc(1); chk("t6_k1_wide", btn_pulse, 4'b0000);
        btn_raw = 4'b0000; cyc(10);
        btn_raw = 4'b0100; press_expect("t6_k3", 4'b0100, 1'b0);
        cyc(1); chk("t6_k3_wide", btn_pulse, 4'b0000);
        btn_raw = 4'b0000; cyc(10);
        btn_raw = 4'b0010; press_expect("t6_k2", 4'b0010, 1'b0);
        cyc(1); chk("t6_k2_wide", btn_pulse, 4'b0000);
        btn_raw = 4'b0000; cyc(10);
        btn_raw = 4'b1000; press_expect("t6_k4", 4'b1000, 1'b0);
        cyc(1); chk("t6_k4_wide", btn_pulse, 4'b0000);
        btn_raw = 4'b0000; cyc(10);
        chk("t6_end_act", activity, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
